// File: rtl/regfile_ecall_unit_if.sv
// regfile_ecall_unit_if: register-file ports, ecall I/O handshakes and status outputs
interface regfile_ecall_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int LED_W  = 8
);
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   write_data;
    logic              reg_write;
    logic              ecall;
    logic [XLEN-1:0]   read_data1;
    logic [XLEN-1:0]   read_data2;
    logic [XLEN-1:0]   in_data;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   out_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   test_case;
    logic              stall;
    logic              halted;
    logic [LED_W-1:0]  led_out;

    modport master (
        output rs1, rs2, rd, write_data, reg_write, ecall, in_data, in_valid, out_ready, test_case,
        input  read_data1, read_data2, in_ready, out_data, out_valid, stall, halted, led_out
    );

    modport slave (
        input  rs1, rs2, rd, write_data, reg_write, ecall, in_data, in_valid, out_ready, test_case,
        output read_data1, read_data2, in_ready, out_data, out_valid, stall, halted, led_out
    );
endinterface

// File: rtl/regfile_ecall_unit.sv
// regfile_ecall_unit: 2R/1W register file with bypass and a blocking ecall service FSM
module regfile_ecall_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int A7_IDX = 17,
    parameter int BYPASS = 1,
    parameter int LED_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    regfile_ecall_unit_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] A0 = ADDR_W'(10);
    localparam logic [ADDR_W-1:0] A7 = ADDR_W'(A7_IDX);

    typedef enum logic [2:0] {IDLE, OUT_WAIT, IN_WAIT, DONE, HALT} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   regs_q [NREG];
    logic [XLEN-1:0]   regs_d [NREG];
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              halted_q, halted_d;
    logic              led_tc_q, led_tc_d;
    logic              led_err_q, led_err_d;
    logic              in_ready_c;
    logic [LED_W-1:0]  led_c;
    logic [XLEN-1:0]   a7;
    logic              wr_ok;
    logic              blocking_code;

    assign a7            = regs_q[A7];
    assign wr_ok         = bus.reg_write && bus.rd != '0 && state_q == IDLE && !bus.ecall;
    assign blocking_code = a7 == XLEN'(1) || a7 == XLEN'(5) || a7 == XLEN'(10);

    assign bus.read_data1 = (bus.rs1 == '0) ? '0 :
                            (BYPASS != 0 && wr_ok && bus.rd == bus.rs1) ? bus.write_data : regs_q[bus.rs1];
    assign bus.read_data2 = (bus.rs2 == '0) ? '0 :
                            (BYPASS != 0 && wr_ok && bus.rd == bus.rs2) ? bus.write_data : regs_q[bus.rs2];
    assign bus.stall      = state_q == OUT_WAIT || state_q == IN_WAIT || state_q == HALT ||
                            (state_q == IDLE && bus.ecall && blocking_code);
    assign bus.in_ready   = in_ready_c;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.halted     = halted_q;
    assign bus.led_out    = led_c;

    // Next-state, register writeback and ecall side effects; ecall beats a same-cycle write
    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        led_tc_d    = 1'b0;
        led_err_d   = led_err_q;
        in_ready_c  = 1'b0;
        if (wr_ok) regs_d[bus.rd] = bus.write_data;
        case (state_q)
            IDLE: if (bus.ecall) begin
                if (a7 == XLEN'(1)) begin
                    out_data_d  = regs_q[A0];
                    out_valid_d = 1'b1;
                    state_d     = OUT_WAIT;
                end else if (a7 == XLEN'(5)) begin
                    state_d = IN_WAIT;
                end else if (a7 == XLEN'(10)) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else if (a7 == XLEN'(11)) begin
                    regs_d[A0] = bus.test_case;
                    led_tc_d   = 1'b1;
                end else begin
                    led_err_d = 1'b1;
                end
            end
            OUT_WAIT: if (bus.out_ready) begin
                out_valid_d = 1'b0;
                state_d     = DONE;
            end
            IN_WAIT: if (bus.in_valid) begin
                in_ready_c = 1'b1;
                regs_d[A0] = bus.in_data;
                state_d    = DONE;
            end
            DONE:    state_d = IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Status LEDs: exit, test-case pulse, sticky bad code, waiting for input
    always_comb begin
        led_c          = '0;
        led_c[0]       = halted_q;
        led_c[1]       = led_tc_q;
        led_c[2]       = led_err_q;
        led_c[LED_W-1] = state_q == IN_WAIT;
    end

    // State registers; async reset drops any pending handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            led_tc_q    <= 1'b0;
            led_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            led_tc_q    <= led_tc_d;
            led_err_q   <= led_err_d;
        end
    end
endmodule

// File: tb/tb_regfile_ecall_unit.sv
// tb_regfile_ecall_unit: directed checks of register file and ecall FSM with a print scoreboard
module tb_regfile_ecall_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    regfile_ecall_unit_if #(.XLEN(32), .ADDR_W(5), .LED_W(8)) bus ();

    regfile_ecall_unit #(.XLEN(32), .ADDR_W(5), .A7_IDX(17), .BYPASS(1), .LED_W(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        bus.rd = r;
        bus.write_data = v;
        bus.reg_write = 1'b1;
        tick();
        bus.reg_write = 1'b0;
    endtask

    // Scoreboard: every accepted print must match the next expected value
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("print_data", bus.out_data, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.write_data = '0; bus.reg_write = 1'b0;
        bus.ecall = 1'b0; bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.test_case = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_led", 32'(bus.led_out), 0);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        // write bypass and x0
        bus.rd = 5'd5; bus.write_data = 32'hDEADBEEF; bus.reg_write = 1'b1; bus.rs1 = 5'd5; bus.rs2 = 5'd5;
        #1;
        chk("bypass_rd1", bus.read_data1, 32'hDEADBEEF);
        chk("bypass_rd2", bus.read_data2, 32'hDEADBEEF);
        tick();
        bus.reg_write = 1'b0;
        #1 chk("array_rd1", bus.read_data1, 32'hDEADBEEF);
        bus.rd = 5'd0; bus.write_data = 32'd7; bus.reg_write = 1'b1; bus.rs1 = 5'd0;
        #1 chk("x0_bypass", bus.read_data1, 0);
        tick();
        bus.reg_write = 1'b0;
        #1 chk("x0_read", bus.read_data1, 0);
        // print with back-pressure
        wr(5'd10, 32'd42);
        wr(5'd17, 32'd1);
        exp_q.push_back(32'd42);
        bus.ecall = 1'b1; bus.out_ready = 1'b0;
        #1 chk("print_ecall_stall", 32'(bus.stall), 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("print_wait_valid", 32'(bus.out_valid), 1);
            chk("print_wait_data", bus.out_data, 32'd42);
            chk("print_wait_stall", 32'(bus.stall), 1);
            tick();
        end
        bus.out_ready = 1'b1;
        #1 chk("print_hs_stall", 32'(bus.stall), 1);
        tick();
        chk("print_done_valid", 32'(bus.out_valid), 0);
        chk("print_done_stall", 32'(bus.stall), 0);
        bus.out_ready = 1'b0; bus.ecall = 1'b0;
        tick();
        chk("print_idle_valid", 32'(bus.out_valid), 0);
        chk("print_sb_drained", 32'(exp_q.size()), 0);
        // read input, then print it back
        wr(5'd17, 32'd5);
        bus.ecall = 1'b1;
        #1 chk("in_ecall_stall", 32'(bus.stall), 1);
        chk("in_ecall_ready", 32'(bus.in_ready), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("in_wait_led7", 32'(bus.led_out[7]), 1);
            chk("in_wait_stall", 32'(bus.stall), 1);
            chk("in_wait_ready", 32'(bus.in_ready), 0);
            tick();
        end
        bus.in_valid = 1'b1; bus.in_data = 32'h1234;
        #1 chk("in_accept_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        chk("in_done_ready", 32'(bus.in_ready), 0);
        chk("in_done_stall", 32'(bus.stall), 0);
        chk("in_done_led7", 32'(bus.led_out[7]), 0);
        bus.ecall = 1'b0;
        tick();
        bus.rs1 = 5'd10;
        #1 chk("in_a0", bus.read_data1, 32'h1234);
        exp_q.push_back(32'h1234);
        wr(5'd17, 32'd1);
        bus.ecall = 1'b1; bus.out_ready = 1'b1;
        tick();
        chk("echo_valid", 32'(bus.out_valid), 1);
        tick();
        chk("echo_done_valid", 32'(bus.out_valid), 0);
        bus.ecall = 1'b0; bus.out_ready = 1'b0;
        tick();
        // test-case ecall beats a simultaneous write to a0
        wr(5'd17, 32'd11);
        bus.test_case = 32'd3; bus.ecall = 1'b1;
        bus.rd = 5'd10; bus.write_data = 32'h55; bus.reg_write = 1'b1; bus.rs1 = 5'd10;
        #1;
        chk("tc_stall", 32'(bus.stall), 0);
        chk("tc_no_bypass", bus.read_data1, 32'h1234);
        tick();
        bus.ecall = 1'b0; bus.reg_write = 1'b0;
        #1;
        chk("tc_a0", bus.read_data1, 32'd3);
        chk("tc_led1_on", 32'(bus.led_out[1]), 1);
        chk("tc_stall_after", 32'(bus.stall), 0);
        tick();
        chk("tc_led1_off", 32'(bus.led_out[1]), 0);
        // unknown code sets sticky error LED
        wr(5'd17, 32'd99);
        bus.ecall = 1'b1;
        #1 chk("err_stall", 32'(bus.stall), 0);
        tick();
        bus.ecall = 1'b0;
        chk("err_led2", 32'(bus.led_out[2]), 1);
        chk("err_a0", bus.read_data1, 32'd3);
        tick();
        chk("err_led_sticky", 32'(bus.led_out), 32'h04);
        // async reset during OUT_WAIT
        wr(5'd17, 32'd1);
        bus.ecall = 1'b1; bus.out_ready = 1'b0;
        tick();
        chk("rst_ow_valid", 32'(bus.out_valid), 1);
        chk("rst_ow_data", bus.out_data, 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("rst_ow_valid_low", 32'(bus.out_valid), 0);
        chk("rst_ow_data_low", bus.out_data, 0);
        chk("rst_ow_stall", 32'(bus.stall), 0);
        chk("rst_ow_led", 32'(bus.led_out), 0);
        bus.ecall = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        // exit ecall halts for good
        wr(5'd17, 32'd10);
        bus.ecall = 1'b1;
        #1 chk("halt_ecall_stall", 32'(bus.stall), 1);
        tick();
        bus.ecall = 1'b0;
        chk("halt_halted", 32'(bus.halted), 1);
        chk("halt_led0", 32'(bus.led_out[0]), 1);
        chk("halt_stall", 32'(bus.stall), 1);
        bus.ecall = 1'b1; bus.rd = 5'd5; bus.write_data = 32'd1; bus.reg_write = 1'b1; bus.rs1 = 5'd5;
        tick();
        tick();
        bus.reg_write = 1'b0;
        chk("halt_no_print", 32'(bus.out_valid), 0);
        chk("halt_sticky", 32'(bus.halted), 1);
        chk("halt_stall_held", 32'(bus.stall), 1);
        chk("halt_no_write", bus.read_data1, 0);
        reset = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(bus.halted), 0);
        chk("halt_rst_led", 32'(bus.led_out), 0);
        chk("halt_rst_stall", 32'(bus.stall), 0);
        chk("halt_rst_valid", 32'(bus.out_valid), 0);
        bus.ecall = 1'b0; bus.rs1 = 5'd17;
        #1 chk("halt_rst_a7", bus.read_data1, 0);
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
